// File: rtl/apb_master_bridge.sv
// apb_master_bridge: single-outstanding command -> APB requester.
// The bus has no PREADY, so the access phase lasts a fixed ACCESS_CYCLES and
// read data is taken in DONE, once the slave's registered PRDATA has settled.
module apb_master_bridge #(
    parameter int ADDR_W        = 4,
    parameter int DATA_W        = 16,
    parameter int ACCESS_CYCLES = 2
) (
    input  logic              PCLK,
    input  logic              RST_N,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    output logic              rsp_write,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              busy,
    output logic              PSEL,
    output logic              PENABLE,
    output logic              PWRITE,
    output logic [ADDR_W-1:0] PADDR,
    output logic [DATA_W-1:0] PWDATA,
    input  logic [DATA_W-1:0] PRDATA
);

    // A zero or negative access length would make no sense on the bus.
    localparam int ACC   = (ACCESS_CYCLES < 1) ? 1 : ACCESS_CYCLES;
    localparam int CNT_W = (ACC > 1) ? $clog2(ACC) : 1;

    typedef enum logic [3:0] {
        IDLE   = 4'b0001,
        SETUP  = 4'b0010,
        ACCESS = 4'b0100,
        DONE   = 4'b1000
    } state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                psel_q, psel_d;
    logic                penable_q, penable_d;
    logic                pwrite_q, pwrite_d;
    logic [ADDR_W-1:0]   paddr_q, paddr_d;
    logic [DATA_W-1:0]   pwdata_q, pwdata_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic                rsp_write_q, rsp_write_d;
    logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic                busy_q, busy_d;

    assign cmd_ready = (state_q == IDLE) && RST_N;

    assign PSEL      = psel_q;
    assign PENABLE   = penable_q;
    assign PWRITE    = pwrite_q;
    assign PADDR     = paddr_q;
    assign PWDATA    = pwdata_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_write = rsp_write_q;
    assign rsp_rdata = rsp_rdata_q;
    assign busy      = busy_q;

    // Next state plus next values of every registered output.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        pwrite_d    = pwrite_q;
        paddr_d     = paddr_q;
        pwdata_d    = pwdata_q;
        rsp_valid_d = 1'b0;
        rsp_write_d = rsp_write_q;
        rsp_rdata_d = rsp_rdata_q;

        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    pwrite_d = cmd_write;
                    paddr_d  = cmd_addr;
                    pwdata_d = cmd_wdata;
                    state_d  = SETUP;
                end
            end
            SETUP: begin
                cnt_d   = CNT_W'(ACC - 1);
                state_d = ACCESS;
            end
            ACCESS: begin
                if (cnt_q == '0) state_d = DONE;
                else             cnt_d   = cnt_q - CNT_W'(1);
            end
            DONE: begin
                // Strobe appears in the first IDLE cycle after DONE.
                rsp_valid_d = 1'b1;
                rsp_write_d = pwrite_q;
                rsp_rdata_d = pwrite_q ? '0 : PRDATA;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Bus controls follow the state they will be presented in.
        psel_d    = (state_d == SETUP) || (state_d == ACCESS);
        penable_d = (state_d == ACCESS);
        busy_d    = (state_d != IDLE);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge PCLK) begin
        if (!RST_N) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_write_q <= 1'b0;
            rsp_rdata_q <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            pwrite_q    <= pwrite_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_write_q <= rsp_write_d;
            rsp_rdata_q <= rsp_rdata_d;
            busy_q      <= busy_d;
        end
    end

endmodule

// File: tb/tb_apb_master_bridge.sv
// Directed bench for apb_master_bridge: default build with a 16-entry
// register slave, plus ACCESS_CYCLES=1 and =4 builds for access length.
module tb_apb_master_bridge;

    logic        PCLK = 1'b0;
    logic        RST_N;
    logic        cmd_valid [3];
    logic        cmd_write;
    logic [3:0]  cmd_addr;
    logic [15:0] cmd_wdata;

    logic        cmd_ready [3];
    logic        rsp_valid [3];
    logic        rsp_write [3];
    logic [15:0] rsp_rdata [3];
    logic        busy      [3];
    logic        psel      [3];
    logic        penable   [3];
    logic        pwrite    [3];
    logic [3:0]  paddr     [3];
    logic [15:0] pwdata    [3];

    logic [15:0] slv_mem [16];
    logic [15:0] slv_rdata;

    int acc_of [3] = '{2, 1, 4};
    int n_chk  = 0;
    int n_fail = 0;

    always #5 PCLK = ~PCLK;

    apb_master_bridge #(.ADDR_W(4), .DATA_W(16), .ACCESS_CYCLES(2)) u_dut0 (
        .PCLK(PCLK), .RST_N(RST_N),
        .cmd_valid(cmd_valid[0]), .cmd_ready(cmd_ready[0]), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid[0]), .rsp_write(rsp_write[0]), .rsp_rdata(rsp_rdata[0]),
        .busy(busy[0]), .PSEL(psel[0]), .PENABLE(penable[0]), .PWRITE(pwrite[0]),
        .PADDR(paddr[0]), .PWDATA(pwdata[0]), .PRDATA(slv_rdata));

    apb_master_bridge #(.ADDR_W(4), .DATA_W(16), .ACCESS_CYCLES(1)) u_dut1 (
        .PCLK(PCLK), .RST_N(RST_N),
        .cmd_valid(cmd_valid[1]), .cmd_ready(cmd_ready[1]), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid[1]), .rsp_write(rsp_write[1]), .rsp_rdata(rsp_rdata[1]),
        .busy(busy[1]), .PSEL(psel[1]), .PENABLE(penable[1]), .PWRITE(pwrite[1]),
        .PADDR(paddr[1]), .PWDATA(pwdata[1]), .PRDATA(16'hBEEF));

    apb_master_bridge #(.ADDR_W(4), .DATA_W(16), .ACCESS_CYCLES(4)) u_dut2 (
        .PCLK(PCLK), .RST_N(RST_N),
        .cmd_valid(cmd_valid[2]), .cmd_ready(cmd_ready[2]), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid[2]), .rsp_write(rsp_write[2]), .rsp_rdata(rsp_rdata[2]),
        .busy(busy[2]), .PSEL(psel[2]), .PENABLE(penable[2]), .PWRITE(pwrite[2]),
        .PADDR(paddr[2]), .PWDATA(pwdata[2]), .PRDATA(16'hBEEF));

    // Register slave: PRDATA registered from SETUP onward, writes commit in ACCESS,
    // reset clears the array and wins over a same-edge write.
    always_ff @(posedge PCLK) begin
        if (!RST_N) begin
            for (int i = 0; i < 16; i++) slv_mem[i] <= '0;
            slv_rdata <= '0;
        end else begin
            if (psel[0] && !pwrite[0]) slv_rdata <= slv_mem[paddr[0]];
            if (psel[0] && penable[0] && pwrite[0]) slv_mem[paddr[0]] <= pwdata[0];
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Issue one command to DUT idx at a negedge where it is idle and check the
    // whole transfer cycle by cycle. Returns at the negedge of the rsp cycle,
    // where the next command may already be presented.
    task automatic do_cmd(input int idx, input bit w, input logic [3:0] a,
                          input logic [15:0] d, input logic [15:0] er, input bit drop);
        int n = acc_of[idx];
        cmd_valid[idx] = 1'b1;
        cmd_write      = w;
        cmd_addr       = a;
        cmd_wdata      = d;
        chk("ready_idle", 32'(cmd_ready[idx]), 1);
        @(negedge PCLK);                       // SETUP
        if (drop) cmd_valid[idx] = 1'b0;
        chk("setup_psel",    32'(psel[idx]), 1);
        chk("setup_penable", 32'(penable[idx]), 0);
        chk("setup_pwrite",  32'(pwrite[idx]), 32'(w));
        chk("setup_paddr",   32'(paddr[idx]), 32'(a));
        chk("setup_pwdata",  32'(pwdata[idx]), 32'(d));
        chk("setup_busy",    32'(busy[idx]), 1);
        chk("setup_rsp",     32'(rsp_valid[idx]), 0);
        chk("setup_ready",   32'(cmd_ready[idx]), 0);
        for (int k = 0; k < n; k++) begin      // ACCESS
            @(negedge PCLK);
            chk("acc_psel",    32'(psel[idx]), 1);
            chk("acc_penable", 32'(penable[idx]), 1);
            chk("acc_paddr",   32'(paddr[idx]), 32'(a));
            chk("acc_pwdata",  32'(pwdata[idx]), 32'(d));
            chk("acc_ready",   32'(cmd_ready[idx]), 0);
        end
        @(negedge PCLK);                       // DONE
        chk("done_psel",    32'(psel[idx]), 0);
        chk("done_penable", 32'(penable[idx]), 0);
        chk("done_busy",    32'(busy[idx]), 1);
        chk("done_paddr",   32'(paddr[idx]), 32'(a));
        chk("done_pwrite",  32'(pwrite[idx]), 32'(w));
        chk("done_rsp",     32'(rsp_valid[idx]), 0);
        @(negedge PCLK);                       // response
        chk("rsp_valid", 32'(rsp_valid[idx]), 1);
        chk("rsp_write", 32'(rsp_write[idx]), 32'(w));
        chk("rsp_rdata", 32'(rsp_rdata[idx]), 32'(er));
        chk("rsp_busy",  32'(busy[idx]), 0);
        chk("rsp_psel",  32'(psel[idx]), 0);
    endtask

    initial begin
        RST_N = 1'b0;
        for (int i = 0; i < 3; i++) cmd_valid[i] = 1'b1;
        cmd_write = 1'b1;
        cmd_addr  = 4'd9;
        cmd_wdata = 16'h1357;

        // Reset held two cycles with cmd_valid asserted.
        repeat (2) begin
            @(negedge PCLK);
            for (int i = 0; i < 3; i++) begin
                chk("rst_psel",    32'(psel[i]), 0);
                chk("rst_penable", 32'(penable[i]), 0);
                chk("rst_ready",   32'(cmd_ready[i]), 0);
                chk("rst_rsp",     32'(rsp_valid[i]), 0);
                chk("rst_busy",    32'(busy[i]), 0);
            end
            chk("rst_paddr",  32'(paddr[0]), 0);
            chk("rst_pwdata", 32'(pwdata[0]), 0);
            chk("rst_rdata",  32'(rsp_rdata[0]), 0);
            chk("rst_pwrite", 32'(pwrite[0]), 0);
        end
        RST_N = 1'b1;
        for (int i = 0; i < 3; i++) cmd_valid[i] = 1'b0;
        @(negedge PCLK);
        for (int i = 0; i < 3; i++) begin
            chk("post_rst_ready", 32'(cmd_ready[i]), 1);
            chk("post_rst_psel",  32'(psel[i]), 0);
        end

        // Single write then read-back.
        do_cmd(0, 1'b1, 4'd3, 16'hA5A5, 16'h0000, 1'b1);
        do_cmd(0, 1'b0, 4'd3, 16'h0000, 16'hA5A5, 1'b1);

        // Back-to-back with cmd_valid held throughout.
        for (int a = 0; a < 16; a++)
            do_cmd(0, 1'b1, 4'(a), 16'(a * 16'h1111), 16'h0000, 1'b0);
        for (int a = 0; a < 16; a++)
            do_cmd(0, 1'b0, 4'(a), 16'h0000, 16'(a * 16'h1111), 1'b0);
        cmd_valid[0] = 1'b0;

        // Response strobe is one cycle and read data holds afterwards.
        @(negedge PCLK);
        chk("rsp_one_cycle", 32'(rsp_valid[0]), 0);
        chk("rdata_hold",    32'(rsp_rdata[0]), 32'h0000FFFF);

        // Reset in the first ACCESS cycle of a write.
        cmd_valid[0] = 1'b1;
        cmd_write    = 1'b1;
        cmd_addr     = 4'd5;
        cmd_wdata    = 16'h1234;
        @(negedge PCLK);
        cmd_valid[0] = 1'b0;
        chk("mid_setup_psel", 32'(psel[0]), 1);
        @(negedge PCLK);
        chk("mid_acc_penable", 32'(penable[0]), 1);
        RST_N = 1'b0;
        @(negedge PCLK);
        chk("mid_rst_psel",    32'(psel[0]), 0);
        chk("mid_rst_penable", 32'(penable[0]), 0);
        chk("mid_rst_ready",   32'(cmd_ready[0]), 0);
        chk("mid_rst_busy",    32'(busy[0]), 0);
        chk("mid_rst_rsp",     32'(rsp_valid[0]), 0);
        RST_N = 1'b1;
        repeat (3) begin
            @(negedge PCLK);
            chk("mid_no_rsp", 32'(rsp_valid[0]), 0);
        end
        do_cmd(0, 1'b0, 4'd5, 16'h0000, 16'h0000, 1'b1);
        do_cmd(0, 1'b0, 4'd3, 16'h0000, 16'h0000, 1'b1);

        // Other access lengths.
        do_cmd(1, 1'b1, 4'd7, 16'h7777, 16'h0000, 1'b1);
        do_cmd(1, 1'b0, 4'd7, 16'h0000, 16'hBEEF, 1'b1);
        do_cmd(2, 1'b1, 4'd9, 16'h9999, 16'h0000, 1'b1);
        do_cmd(2, 1'b0, 4'd9, 16'h0000, 16'hBEEF, 1'b1);
        @(negedge PCLK);
        chk("acc4_rsp_one_cycle", 32'(rsp_valid[2]), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/apb_master_bridge.md
Name: apb_master_bridge

Overview:
- Single-outstanding APB requester that sits directly upstream of the 16-entry APB register/RAM slave.
- Converts a simple valid/ready command interface into APB SETUP/ACCESS sequences on PSEL/PENABLE/PADDR/PWRITE/PWDATA.
- Captures PRDATA and returns read results on a one-cycle response strobe.
- The APB bus in this subsystem has no PREADY. Access-phase length is therefore fixed by parameter, and read data is sampled one cycle after the access phase ends, when the slave's registered PRDATA is valid.

Parameters:
- ADDR_W, 4, width of cmd_addr/PADDR.
- DATA_W, 16, width of write/read data.
- ACCESS_CYCLES, 2, cycles PENABLE is held high per transfer. Values <1 are clamped to 1. Default 2 matches the slave's IDLE->SETUP->PHASE walk.

Ports:
- PCLK  in  1  clock; all logic on rising edge.
- RST_N  in  1  synchronous, active-low reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  bridge can accept a command this cycle.
- cmd_write  in  1  1=write, 0=read.
- cmd_addr  in  ADDR_W  target address.
- cmd_wdata  in  DATA_W  write data; ignored for reads.
- rsp_valid  out  1  one-cycle completion strobe.
- rsp_write  out  1  type of the completed command.
- rsp_rdata  out  DATA_W  read data; 0 for completed writes.
- busy  out  1  high from acceptance through DONE.
- PSEL  out  1  APB select.
- PENABLE  out  1  APB enable.
- PWRITE  out  1  APB direction.
- PADDR  out  ADDR_W  APB address.
- PWDATA  out  DATA_W  APB write data.
- PRDATA  in  DATA_W  APB read data from slave (registered by slave).

Behaviour:
- Reset: when RST_N is low at a rising edge, the next cycle has state=IDLE and PSEL=PENABLE=PWRITE=0, PADDR=0, PWDATA=0, rsp_valid=0, rsp_write=0, rsp_rdata=0, busy=0, access counter=0.
- Reset mid-transfer: the transfer is dropped with no rsp_valid. cmd_ready is 0 while RST_N is low.
- All APB outputs and rsp_* are driven from flops. cmd_ready = (state==IDLE) && RST_N.
- FSM states: IDLE, SETUP, ACCESS, DONE. The encoding is one-hot; an illegal encoding goes to IDLE.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid&&cmd_ready, latch write/addr/wdata into PWRITE/PADDR/PWDATA, then go to SETUP.
  - PADDR/PWRITE/PWDATA otherwise hold their last values.
- SETUP (1 cycle): PSEL=1, PENABLE=0; then go to ACCESS and load counter=ACCESS_CYCLES-1.
- ACCESS:
  - PSEL=1, PENABLE=1.
  - Decrement the counter each cycle. At counter==0, go to DONE.
  - PENABLE is high for exactly ACCESS_CYCLES consecutive cycles.
- DONE (1 cycle):
  - PSEL=0, PENABLE=0.
  - For reads, sample PRDATA into rsp_rdata at the end of this cycle; for writes, load rsp_rdata=0.
  - Then go to IDLE.
- Response: rsp_valid=1 for exactly the first IDLE cycle after DONE, with rsp_write/rsp_rdata valid. rsp_rdata holds until the next completion or reset.
- A new command may be accepted in that same cycle.
- Timing, for acceptance at cycle t:
  - SETUP at t+1.
  - ACCESS at t+2..t+1+ACCESS_CYCLES.
  - DONE at t+2+ACCESS_CYCLES.
  - rsp_valid at t+3+ACCESS_CYCLES.
  - Minimum command period is ACCESS_CYCLES+3 (5 at default).
- PSEL is guaranteed low for at least one cycle (DONE) between transfers.
- PADDR/PWRITE/PWDATA are stable from SETUP through DONE.
- busy=1 in SETUP/ACCESS/DONE.
- cmd_valid while not ready is ignored. cmd_* must be held by the source until accepted.

Test Plan:
- Reset then idle: RST_N=0 for 2 cycles with cmd_valid=1 -> PSEL=PENABLE=0, cmd_ready=0, rsp_valid never asserted. After release, cmd_ready=1 next cycle.
- Write 0xA5A5 to addr 3 at cycle t -> PSEL rises t+1; PENABLE high t+2..t+3; PWRITE=1, PADDR=3, PWDATA=0xA5A5 stable t+1..t+4; rsp_valid=1 at t+5 with rsp_write=1, rsp_rdata=0.
- Read addr 3 after that write, with the slave model attached -> PENABLE high 2 cycles; rsp_valid at t+5 with rsp_rdata=0xA5A5, rsp_write=0.
- Back-to-back: cmd_valid held with writes to addrs 0..15 (data=addr*0x1111), then reads of 0..15 -> one acceptance every 5 cycles, PSEL low ≥1 cycle between transfers, all 16 reads return the written values.
- Reset mid-ACCESS: RST_N=0 in the first ACCESS cycle of a write -> next cycle PSEL=PENABLE=0, no rsp_valid. A subsequent read of that address returns 0 after slave reset.
- ACCESS_CYCLES=1 and 4 builds -> PENABLE high for exactly 1/4 cycles, rsp_valid at t+4/t+7.
